// File: rtl/sphere_update_ctrl_pkg.sv
// Shared types, constants and helpers for the per-frame sphere physics sequencer.
// Vectors are three signed Q32.32 elements; element [2] is the vertical axis.
package sphere_update_ctrl_pkg;
  typedef logic signed [63:0] fixed_real;
  typedef logic [2:0][63:0]   vector;
  typedef logic [23:0]        color;

  localparam fixed_real FLOOR_X     = fixed_real'(64'd1440 << 32);
  localparam vector     ACC         = {64'hFFFFFFFE00000000, 64'd0, 64'd0};
  localparam vector     RESPAWN_POS = {64'd0, 64'd304 << 32, 64'd0};
  localparam color      SPHERE_COL [4] = '{24'hFF4040, 24'h40FF40, 24'h4040FF, 24'hFFFF40};

  // Respawn launch velocity: upward element is always positive, the two others sign-extend from Rand[0]/Rand[1].
  function automatic vector rand_to_vel(input logic [63:0] r);
    return {{16'd0, r[63:48], 32'd0},
            {{16{r[0]}}, r[47:32], 32'd0},
            {{16{r[1]}}, r[31:16], 32'd0}};
  endfunction

  function automatic vector init_pos(input int k);
    logic [63:0] z;
    z = 64'(k * 128 - 192) << 32;
    return {64'd0, 64'd304 << 32, z};
  endfunction
endpackage

// File: rtl/sphere_update_ctrl_if.sv
// Control, hit and renderer read-port signals of the sphere update sequencer.
interface sphere_update_ctrl_if;
  import sphere_update_ctrl_pkg::*;

  logic        Frame_Start;
  logic [63:0] Rand;
  logic        Hit;
  logic [1:0]  Hit_index;
  logic [1:0]  Read_index;
  vector       Sphere_pos;
  color        Sphere_col;
  logic        Busy;
  logic        Done;
  logic        Overrun;

  modport master (
    output Frame_Start, Rand, Hit, Hit_index, Read_index,
    input  Sphere_pos, Sphere_col, Busy, Done, Overrun
  );

  modport slave (
    input  Frame_Start, Rand, Hit, Hit_index, Read_index,
    output Sphere_pos, Sphere_col, Busy, Done, Overrun
  );
endinterface

// File: rtl/sphere_update_ctrl_add_vector.sv
// Element-wise 64-bit wrapping vector adder, shared by the velocity and position steps.
module add_vector
  import sphere_update_ctrl_pkg::*;
(
  input  vector a,
  input  vector b,
  output vector sum
);
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_elem
      assign sum[gi] = a[gi] + b[gi];
    end
  endgenerate
endmodule

// File: rtl/sphere_update_ctrl.sv
// Serial per-frame physics pass over four spheres with shadow state and atomic commit.
// The renderer only ever sees committed state, which changes on the COMMIT edge.
module sphere_update_ctrl #(
  parameter int          NUM_SPHERES = 4,
  parameter logic [63:0] FLOOR_X     = 64'd1440 << 32
) (
  input logic            Clk,
  input logic            Reset,
  sphere_update_ctrl_if.slave bus
);
  import sphere_update_ctrl_pkg::*;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VEL    = 3'd1;
  localparam logic [2:0] POS    = 3'd2;
  localparam logic [2:0] CHK    = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;
  localparam logic [1:0] LAST_IDX = 2'(NUM_SPHERES - 1);

  logic [2:0]             state_reg, state_next;
  logic [1:0]             idx_reg;
  vector                  pos_reg   [NUM_SPHERES];
  vector                  vel_reg   [NUM_SPHERES];
  vector                  pos_s_reg [NUM_SPHERES];
  vector                  vel_s_reg [NUM_SPHERES];
  logic [NUM_SPHERES-1:0] hit_pend_reg, hit_pend_next;
  logic [NUM_SPHERES-1:0] serviced_reg;
  logic [NUM_SPHERES-1:0] hit_set, hit_clr;
  logic                   overrun_reg;
  vector                  add_a, add_b, add_sum;
  logic                   floor_hit, respawn;

  assign add_a = (state_reg == VEL) ? vel_reg[idx_reg] : pos_reg[idx_reg];
  assign add_b = (state_reg == VEL) ? ACC : vel_s_reg[idx_reg];

  add_vector u_add (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  // Floor test looks at the committed position, not the freshly computed shadow.
  assign floor_hit = pos_reg[idx_reg][2][63] && ((64'd0 - pos_reg[idx_reg][2]) > FLOOR_X);
  assign respawn   = floor_hit || hit_pend_reg[idx_reg] || (bus.Hit && (bus.Hit_index == idx_reg));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.Frame_Start) state_next = VEL;
      VEL:     state_next = POS;
      POS:     state_next = CHK;
      CHK:     state_next = (idx_reg == LAST_IDX) ? COMMIT : VEL;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    hit_set = '0;
    if (bus.Hit) hit_set[bus.Hit_index] = 1'b1;
    hit_clr = (state_reg == COMMIT) ? serviced_reg : '0;
    hit_pend_next = (hit_pend_reg & ~hit_clr) | hit_set;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      idx_reg      <= 2'd0;
      hit_pend_reg <= '0;
      serviced_reg <= '0;
      overrun_reg  <= 1'b0;
      for (int k = 0; k < NUM_SPHERES; k++) begin
        pos_reg[k]   <= init_pos(k);
        vel_reg[k]   <= '0;
        pos_s_reg[k] <= init_pos(k);
        vel_s_reg[k] <= '0;
      end
    end else begin
      state_reg    <= state_next;
      hit_pend_reg <= hit_pend_next;
      if (bus.Frame_Start && (state_reg != IDLE)) overrun_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (bus.Frame_Start) begin
            idx_reg      <= 2'd0;
            serviced_reg <= '0;
          end
        end
        VEL: vel_s_reg[idx_reg] <= add_sum;
        POS: pos_s_reg[idx_reg] <= add_sum;
        CHK: begin
          if (respawn) begin
            pos_s_reg[idx_reg]    <= RESPAWN_POS;
            vel_s_reg[idx_reg]    <= rand_to_vel(bus.Rand);
            serviced_reg[idx_reg] <= 1'b1;
          end
          idx_reg <= idx_reg + 2'd1;
        end
        COMMIT: begin
          for (int k = 0; k < NUM_SPHERES; k++) begin
            pos_reg[k] <= pos_s_reg[k];
            vel_reg[k] <= vel_s_reg[k];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy       = (state_reg != IDLE);
  assign bus.Done       = (state_reg == COMMIT);
  assign bus.Overrun    = overrun_reg;
  assign bus.Sphere_pos = pos_reg[bus.Read_index];
  assign bus.Sphere_col = SPHERE_COL[bus.Read_index];
endmodule

// File: doc/sphere_update_ctrl.md
# sphere_update_ctrl

Per-frame physics sequencer for the four scene spheres. On each frame-start pulse it serially advances every sphere's velocity and position through one shared vector adder, and applies the floor/hit respawn rule with random launch velocities. It commits all four results atomically. The renderer reads a frame-consistent sphere set through a zero-latency read port that changes only on the commit cycle.

## Interface
Parameters:
- NUM_SPHERES, 4, sphere count; the index width is fixed at 2 bits.
- FLOOR_X, 64'd1440 << 32, respawn threshold magnitude for element [2], Q32.32.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high.
- Frame_Start  in  1  one-cycle pulse; starts an update pass.
- Rand  in  64  random word from the LFSR/LUT, sampled in CHK.
- Hit  in  1  sphere hit strobe.
- Hit_index  in  2  sphere hit when Hit=1.
- Read_index  in  2  renderer read select.
- Sphere_pos  out  vector  committed position of Read_index.
- Sphere_col  out  color  SPHERE_COL[Read_index].
- Busy  out  1  high from the cycle after Frame_Start through COMMIT.
- Done  out  1  one-cycle pulse on the COMMIT cycle.
- Overrun  out  1  sticky; set when Frame_Start arrives while Busy.

## Operation
- Storage: committed pos[4] and vel[4]; shadow pos_s[4] and vel_s[4]; hit_pend[4]; serviced[4]; 2-bit sphere counter i.
- Number format: signed Q32.32 per element; vector element [2] is the vertical axis.
- Adds are 64-bit wrapping; there is no saturation.
- FSM states: IDLE, VEL, POS, CHK, COMMIT.
- IDLE: when Frame_Start=1, set i=0, clear serviced, go to VEL.
- VEL: vel_s[i] = vel[i] + ACC, where ACC = {64'hFFFFFFFE00000000, 0, 0} (-2.0 on element [2]).
- POS: pos_s[i] = pos[i] + vel_s[i].
- CHK: the respawn condition is (pos[i][2][63] && -pos[i][2] > FLOOR_X) || hit_pend[i] || (Hit && Hit_index==i). The floor test uses the committed (pre-update) position.
- CHK, condition true:
  - pos_s[i] = {0, 64'd304<<32, 0};
  - vel_s[i] = {16'd0,Rand[63:48],32'd0}, {{16{Rand[0]}},Rand[47:32],32'd0}, {{16{Rand[1]}},Rand[31:16],32'd0};
  - serviced[i] = 1.
- CHK, then: if i==3 go to COMMIT, else i++ and go to VEL.
- COMMIT: pos <= pos_s, vel <= vel_s, hit_pend &= ~serviced, Done=1, then go to IDLE.
- Hit handling: Hit sets hit_pend[Hit_index] in any state.
  - If set and clear hit the same index in the same cycle, set wins, so the flag stays pending.
  - A hit on sphere i that arrives after sphere i's CHK stays pending until the next frame.
- Frame_Start while Busy: ignored and sets Overrun. Only Reset clears Overrun.
- Read port: Sphere_pos and Sphere_col are combinational muxes of committed state; the renderer never sees a half-updated frame.

## Timing
- Reset values:
  - state IDLE, i=0, Busy=0, Done=0, Overrun=0, hit_pend=0;
  - vel[k]=0;
  - pos[k] = {0, 64'd304<<32, ((k*128)-192)<<32};
  - shadow registers equal committed values.
- Pass latency: 3 cycles per sphere, 12 cycles for four spheres, plus 1 COMMIT cycle.
  - Frame_Start in cycle 0 → Done and the new committed state in cycle 13.
  - Sphere_pos reflects the new state from cycle 14.
- Minimum Frame_Start spacing is 14 cycles; a pulse in cycles 1..13 counts as an overrun.
- Reset during a pass aborts it with no partial commit; all registers return to reset values on the next edge.
- Read latency is 0 cycles.

## Structure
- Shared package (extended, not duplicated):
  - typedefs vector, fixed_real, color;
  - constants ACC, RESPAWN_POS, FLOOR_X, SPHERE_COL[4].
- One sub-module, add_vector: a single instance time-shared between VEL (vel+ACC) and POS (pos+vel_s), with its operands muxed by state.
- The respawn-velocity bit packing lives in a package function rand_to_vel(Rand).

## Test plan
- Reset, then one Frame_Start → Done at cycle 13. Sphere 0 reads vel.x = 0xFFFFFFFE00000000 and pos = {-2.0, 304.0, -192.0}; Busy is high for cycles 1..13.
- Second frame → sphere 0 pos.x = -6.0 and vel.x = -4.0. The same result holds for spheres 1..3, with element [0] unchanged (-64.0, 64.0, 192.0).
- 38 frames with no hits → pos.x = -1482.0 after frame 38. Frame 39 respawns all spheres to {0, 304.0, 0} with Rand-derived velocity. Frame 37 → -1406.0 and no respawn.
- Hit with Hit_index=2 in IDLE, then a frame with Rand=0x0001_0002_0003_0000 → sphere 2 pos = {0, 304.0, 0} and vel = {1.0, 2.0, 3.0}. hit_pend[2] clears on COMMIT; the other spheres update normally.
- Hit on index 0 at cycle 10 of a pass (after sphere 0's CHK) → no respawn this frame; respawn on the next frame. A hit on index 3 in its own CHK cycle is serviced in the same pass.
- Frame_Start at cycle 5 → Overrun=1 and Done still occurs at cycle 13. Reset at cycle 8 → committed state equals the reset values and Busy=0.
